// File: rtl/bus_sel_pkg.sv
// rtl/bus_sel_pkg.sv - shared defaults and helpers for the bus channel selector
package bus_sel_pkg;

   localparam int unsigned WIDTH_DEF = 8;
   localparam int unsigned NCH_DEF   = 3;
   localparam int unsigned SELW_DEF  = 2;
   localparam int unsigned CNTW_DEF  = 8;

   // A select is legal only when it names one of the populated channels
   function automatic logic sel_legal(input int unsigned sel, input int unsigned nch);
      return (sel < nch);
   endfunction

   // Largest value a CNTW-bit counter can hold (widths up to 32 bits)
   function automatic int unsigned err_cnt_max(input int unsigned cntw);
      return (cntw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cntw) - 32'd1);
   endfunction

endpackage

// File: rtl/bus_sel_reg_sat_counter.sv
// rtl/bus_sel_reg_sat_counter.sv - saturating counter with synchronous clear
module sat_counter
   import bus_sel_pkg::*;
#(
   parameter int unsigned CNTW = CNTW_DEF
) (
   input  logic            clk,
   input  logic            reset_l,
   input  logic            clr_i,
   input  logic            inc_i,
   output logic [CNTW-1:0] cnt_o
);

   localparam logic [CNTW-1:0] CNT_MAX = CNTW'(err_cnt_max(CNTW));

   logic [CNTW-1:0] cnt_q, cnt_d;

   // Clear first, then count, so a same-cycle clear and increment lands on 1
   always_comb begin
      cnt_d = clr_i ? '0 : cnt_q;
      if (inc_i && (cnt_d != CNT_MAX)) begin
         cnt_d = cnt_d + 1'b1;
      end
   end

   // Counter state register
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/bus_sel_reg.sv
// rtl/bus_sel_reg.sv - registered N-way channel selector with handshake and illegal-select tracking
module bus_sel_reg
   import bus_sel_pkg::*;
#(
   parameter int unsigned WIDTH        = WIDTH_DEF,
   parameter int unsigned NCH          = NCH_DEF,
   parameter int unsigned SELW         = SELW_DEF,
   parameter bit          ILLEGAL_DROP = 1'b0,
   parameter int unsigned CNTW         = CNTW_DEF
) (
   input  logic                 clk,
   input  logic                 reset_l,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [SELW-1:0]      sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_any,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 err_pulse,
   output logic                 err_sticky,
   output logic [CNTW-1:0]      err_cnt,
   input  logic                 clr_err
);

   // With every select value populated there is nothing to flag
   localparam bit HAS_ILLEGAL = (NCH < (2 ** SELW));

   logic [WIDTH-1:0] mux_data;
   logic             sel_illegal;
   logic             accept;
   logic             acc_illegal;

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_any_q, out_any_d;
   logic             err_pulse_q, err_pulse_d;
   logic             err_sticky_q, err_sticky_d;

   assign in_ready    = ~out_valid_q | out_ready;
   assign accept      = in_valid & in_ready;
   assign sel_illegal = HAS_ILLEGAL && !sel_legal(32'(sel), NCH);
   assign acc_illegal = accept & sel_illegal;

   // Indexed channel mux; unpopulated selects fall through to zero
   always_comb begin
      mux_data = '0;
      for (int k = 0; k < int'(NCH); k++) begin
         if (int'(sel) == k) begin
            mux_data = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // Next state of the output stage and the error flags
   always_comb begin
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_any_d    = out_any_q;
      err_pulse_d  = acc_illegal;
      err_sticky_d = (err_sticky_q & ~clr_err) | acc_illegal;
      if (accept) begin
         if (sel_illegal && ILLEGAL_DROP) begin
            out_valid_d = 1'b0;
         end else begin
            out_valid_d = 1'b1;
            out_any_d   = |sel;
`ifdef BEH
            out_data_d  = sel_illegal ? 'x : mux_data;
`else
            out_data_d  = sel_illegal ? '0 : mux_data;
`endif
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output stage and error flag registers; reset discards any pending beat
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_any_q    <= 1'b0;
         err_pulse_q  <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_any_q    <= out_any_d;
         err_pulse_q  <= err_pulse_d;
         err_sticky_q <= err_sticky_d;
`ifdef BEH
         if (acc_illegal) begin
            $display("bus_sel_reg: illegal select %0d", sel);
         end
`endif
      end
   end

   sat_counter #(
      .CNTW (CNTW)
   ) u_err_cnt (
      .clk     (clk),
      .reset_l (reset_l),
      .clr_i   (clr_err),
      .inc_i   (acc_illegal),
      .cnt_o   (err_cnt)
   );

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_any    = out_any_q;
   assign err_pulse  = err_pulse_q;
   assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_bus_sel_reg.sv
// tb/tb_bus_sel_reg.sv - directed self-checking bench for bus_sel_reg in both illegal-select modes
module tb_bus_sel_reg;

   logic        clk = 1'b0;
   logic        reset_l;
   logic [23:0] in_data;
   logic [1:0]  sel;
   logic        in_valid;
   logic        out_ready;
   logic        clr_err;

   logic       a_in_ready, a_out_any, a_out_valid, a_err_pulse, a_err_sticky;
   logic [7:0] a_out_data, a_err_cnt;
   logic       b_in_ready, b_out_any, b_out_valid, b_err_pulse, b_err_sticky;
   logic [7:0] b_out_data, b_err_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bus_sel_reg #(.WIDTH(8), .NCH(3), .SELW(2), .ILLEGAL_DROP(1'b0), .CNTW(8)) dut_emit (
      .clk(clk), .reset_l(reset_l), .in_data(in_data), .sel(sel), .in_valid(in_valid),
      .in_ready(a_in_ready), .out_data(a_out_data), .out_any(a_out_any), .out_valid(a_out_valid),
      .out_ready(out_ready), .err_pulse(a_err_pulse), .err_sticky(a_err_sticky),
      .err_cnt(a_err_cnt), .clr_err(clr_err)
   );

   bus_sel_reg #(.WIDTH(8), .NCH(3), .SELW(2), .ILLEGAL_DROP(1'b1), .CNTW(8)) dut_drop (
      .clk(clk), .reset_l(reset_l), .in_data(in_data), .sel(sel), .in_valid(in_valid),
      .in_ready(b_in_ready), .out_data(b_out_data), .out_any(b_out_any), .out_valid(b_out_valid),
      .out_ready(out_ready), .err_pulse(b_err_pulse), .err_sticky(b_err_sticky),
      .err_cnt(b_err_cnt), .clr_err(clr_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      sel       = 2'd0;
      out_ready = 1'b1;
      clr_err   = 1'b0;
      in_data   = {8'h33, 8'h22, 8'h11};
      reset_l   = 1'b0;
      tick();
      tick();
      reset_l   = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      reset_l = 1'b0;
      #1;
      n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
      n_cmp++; if (a_out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data: got %h expected 00", a_out_data); end
      n_cmp++; if (a_out_any !== 1'b0) begin n_bad++; $display("FAIL reset_out_any: got %b expected 0", a_out_any); end
      n_cmp++; if ({a_err_pulse, a_err_sticky, a_err_cnt} !== 10'd0) begin n_bad++; $display("FAIL reset_err: got %b%b %h expected 0 0 00", a_err_pulse, a_err_sticky, a_err_cnt); end
      n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
      n_cmp++; if ({b_out_valid, b_err_pulse, b_err_sticky, b_err_cnt} !== 11'd0) begin n_bad++; $display("FAIL reset_drop: got %b%b%b %h expected 0 0 0 00", b_out_valid, b_err_pulse, b_err_sticky, b_err_cnt); end
      reset_l = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      do_reset();
      sel = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b expected 1", a_out_valid); end
      n_cmp++; if (a_out_data !== 8'h22) begin n_bad++; $display("FAIL basic_data: got %h expected 22", a_out_data); end
      n_cmp++; if (a_out_any !== 1'b1) begin n_bad++; $display("FAIL basic_any: got %b expected 1", a_out_any); end
      n_cmp++; if (b_out_data !== 8'h22) begin n_bad++; $display("FAIL basic_drop_data: got %h expected 22", b_out_data); end
      n_cmp++; if (a_err_pulse !== 1'b0) begin n_bad++; $display("FAIL basic_no_err: got %b expected 0", a_err_pulse); end
      tick();
      n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drain: got %b expected 0", a_out_valid); end
      n_cmp++; if (a_out_data !== 8'h22) begin n_bad++; $display("FAIL basic_hold: got %h expected 22", a_out_data); end
   endtask

   task automatic test_stream();
      logic [1:0] sels [4];
      logic [7:0] exp_rx [4];
      logic [7:0] rx [8];
      int idx = 0;
      int n = 0;
      logic acc;
      sels   = '{2'd0, 2'd1, 2'd2, 2'd0};
      exp_rx = '{8'h11, 8'h22, 8'h33, 8'h11};
      do_reset();
      for (int c = 0; c < 10; c++) begin
         in_valid  = (idx < 4);
         sel       = (idx < 4) ? sels[idx] : 2'd0;
         out_ready = (c != 2) && (c != 3);
         #1;
         if (c == 2 || c == 3) begin
            n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL stream_stall_ready c%0d: got %b expected 0", c, a_in_ready); end
         end
         if (a_out_valid && out_ready && n < 8) begin
            rx[n] = a_out_data;
            n++;
         end
         acc = in_valid && a_in_ready;
         tick();
         if (acc) idx++;
      end
      n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL stream_count: got %0d expected 4", n); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (rx[i] !== exp_rx[i]) begin n_bad++; $display("FAIL stream_beat%0d: got %h expected %h", i, rx[i], exp_rx[i]); end
      end
   endtask

   task automatic test_illegal();
      do_reset();
      sel = 2'd3; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (a_out_valid !== 1'b1) begin n_bad++; $display("FAIL ill_emit_valid: got %b expected 1", a_out_valid); end
      n_cmp++; if (a_out_data !== 8'h00) begin n_bad++; $display("FAIL ill_emit_data: got %h expected 00", a_out_data); end
      n_cmp++; if (a_out_any !== 1'b1) begin n_bad++; $display("FAIL ill_emit_any: got %b expected 1", a_out_any); end
      n_cmp++; if ({a_err_pulse, a_err_sticky} !== 2'b11) begin n_bad++; $display("FAIL ill_emit_flags: got %b%b expected 11", a_err_pulse, a_err_sticky); end
      n_cmp++; if (a_err_cnt !== 8'd1) begin n_bad++; $display("FAIL ill_emit_cnt: got %0d expected 1", a_err_cnt); end
      n_cmp++; if (b_out_valid !== 1'b0) begin n_bad++; $display("FAIL ill_drop_valid: got %b expected 0", b_out_valid); end
      n_cmp++; if ({b_err_pulse, b_err_sticky} !== 2'b11) begin n_bad++; $display("FAIL ill_drop_flags: got %b%b expected 11", b_err_pulse, b_err_sticky); end
      n_cmp++; if (b_err_cnt !== 8'd1) begin n_bad++; $display("FAIL ill_drop_cnt: got %0d expected 1", b_err_cnt); end
      tick();
      n_cmp++; if ({a_err_pulse, b_err_pulse} !== 2'b00) begin n_bad++; $display("FAIL ill_pulse_width: got %b%b expected 00", a_err_pulse, b_err_pulse); end
      n_cmp++; if ({a_err_sticky, b_err_sticky} !== 2'b11) begin n_bad++; $display("FAIL ill_sticky_hold: got %b%b expected 11", a_err_sticky, b_err_sticky); end
      sel = 2'd3; in_valid = 1'b0;
      tick();
      n_cmp++; if (a_err_cnt !== 8'd1) begin n_bad++; $display("FAIL ill_invalid_ignored: got %0d expected 1", a_err_cnt); end
   endtask

   task automatic test_saturate();
      int drop_seen = 0;
      do_reset();
      sel = 2'd3; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (b_out_valid !== 1'b0) drop_seen++;
         if (i == 9) begin
            n_cmp++; if (b_err_cnt !== 8'd10) begin n_bad++; $display("FAIL sat_cnt10: got %0d expected 10", b_err_cnt); end
         end
      end
      in_valid = 1'b0;
      tick();
      n_cmp++; if (drop_seen !== 0) begin n_bad++; $display("FAIL sat_drop_valid: got %0d valid cycles expected 0", drop_seen); end
      n_cmp++; if (b_err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_drop_cnt: got %0d expected 255", b_err_cnt); end
      n_cmp++; if (a_err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_emit_cnt: got %0d expected 255", a_err_cnt); end
   endtask

   task automatic test_clr_err();
      do_reset();
      sel = 2'd3; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      tick();
      n_cmp++; if (a_err_cnt !== 8'd2) begin n_bad++; $display("FAIL clr_pre_cnt: got %0d expected 2", a_err_cnt); end
      clr_err = 1'b1;
      tick();
      n_cmp++; if (a_err_cnt !== 8'd1) begin n_bad++; $display("FAIL clr_same_cycle_cnt: got %0d expected 1", a_err_cnt); end
      n_cmp++; if (a_err_sticky !== 1'b1) begin n_bad++; $display("FAIL clr_same_cycle_sticky: got %b expected 1", a_err_sticky); end
      in_valid = 1'b0;
      tick();
      n_cmp++; if ({a_err_sticky, a_err_cnt} !== 9'd0) begin n_bad++; $display("FAIL clr_alone: got %b %0d expected 0 0", a_err_sticky, a_err_cnt); end
      n_cmp++; if ({b_err_sticky, b_err_cnt} !== 9'd0) begin n_bad++; $display("FAIL clr_alone_drop: got %b %0d expected 0 0", b_err_sticky, b_err_cnt); end
      clr_err = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      sel = 2'd2; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      n_cmp++; if ({a_out_valid, a_out_data} !== {1'b1, 8'h33}) begin n_bad++; $display("FAIL mid_pending: got %b %h expected 1 33", a_out_valid, a_out_data); end
      #2;
      reset_l = 1'b0;
      #1;
      n_cmp++; if ({a_out_valid, a_out_data, a_out_any} !== 10'd0) begin n_bad++; $display("FAIL mid_async_clear: got %b %h %b expected 0 00 0", a_out_valid, a_out_data, a_out_any); end
      reset_l = 1'b1;
      tick();
      sel = 2'd3; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (a_err_pulse !== 1'b1) begin n_bad++; $display("FAIL mid_err_setup: got %b expected 1", a_err_pulse); end
      reset_l = 1'b0;
      #1;
      n_cmp++; if ({a_err_pulse, a_err_sticky, a_err_cnt} !== 10'd0) begin n_bad++; $display("FAIL mid_err_clear: got %b%b %0d expected 0 0 0", a_err_pulse, a_err_sticky, a_err_cnt); end
      reset_l = 1'b1;
      tick();
      n_cmp++; if ({a_err_pulse, b_err_pulse, a_out_valid} !== 3'b000) begin n_bad++; $display("FAIL mid_no_late_pulse: got %b%b%b expected 000", a_err_pulse, b_err_pulse, a_out_valid); end
   endtask

   initial begin
      reset_l   = 1'b0;
      in_valid  = 1'b0;
      sel       = 2'd0;
      out_ready = 1'b1;
      clr_err   = 1'b0;
      in_data   = {8'h33, 8'h22, 8'h11};
      #1;
      test_reset();
      test_basic();
      test_stream();
      test_illegal();
      test_saturate();
      test_clr_err();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
